// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode encodings, register codes, NOP word, opcode field bounds.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_defs;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;

  // Opcode occupies instruction bits [OPC_HI:OPC_LO].
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [4:0] {
    OP_NOP   = 5'b00000,
    OP_HALT  = 5'b00001,
    OP_LOAD  = 5'b00010,
    OP_STORE = 5'b00011,
    OP_NOR   = 5'b00100,
    OP_NXOR  = 5'b00101,
    OP_NAND  = 5'b00110,
    OP_ADD   = 5'b01000,
    OP_ADDI  = 5'b01001,
    OP_ADDC  = 5'b01010,
    OP_SUB   = 5'b01011,
    OP_SUBI  = 5'b01100,
    OP_SUBC  = 5'b01101,
    OP_CMP   = 5'b01110,
    OP_LDIH  = 5'b10000,
    OP_AND   = 5'b10001,
    OP_OR    = 5'b10010,
    OP_XOR   = 5'b10011,
    OP_SLL   = 5'b10100,
    OP_SRL   = 5'b10101,
    OP_SLA   = 5'b10110,
    OP_SRA   = 5'b10111,
    OP_JUMP  = 5'b11000,
    OP_JMPR  = 5'b11001,
    OP_BZ    = 5'b11010,
    OP_BNZ   = 5'b11011,
    OP_BN    = 5'b11100,
    OP_BNN   = 5'b11101,
    OP_BC    = 5'b11110,
    OP_BNC   = 5'b11111
  } opcode_e;

  localparam logic [4:0] HALT_OP = OP_HALT;

  typedef enum logic [2:0] {
    GR0 = 3'd0, GR1 = 3'd1, GR2 = 3'd2, GR3 = 3'd3,
    GR4 = 3'd4, GR5 = 3'd5, GR6 = 3'd6, GR7 = 3'd7
  } reg_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, its address and a valid bit.
// Latency: 1 edge from load to outputs. Backpressure: holds contents when no control is active.
// Ports: clk, reset (sync, active-high); flush (load bubble + flush_pc), bubble (load bubble,
//   keep pc), load (capture instr_in/pc_in as valid); instr/pc/valid outputs.
module if_id_reg
  import cpu_defs::*;
#(
  parameter int ADDR_W  = cpu_defs::ADDR_W,
  parameter int INSTR_W = cpu_defs::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_defs::NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               bubble,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  // Control precedence mirrors the fetch priority: flush > bubble > load > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      pc    <= flush_pc;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instr_mem, fills IF/ID, handles redirect/halt/stall, counts fetches.
// Latency: word at address A lands in IF/ID one edge after pc==A.
// Backpressure: stall holds PC, IF/ID and counter; redirect overrides stall and halt.
// Ports: clk, reset (sync, active-high); imem_addr/imem_rdata to instr_mem; stall, redirect,
//   redirect_pc from hazard/branch logic; ifid_instr/ifid_pc/ifid_valid, halted, fetch_count out.
module fetch_stage
  import cpu_defs::*;
#(
  parameter int ADDR_W  = cpu_defs::ADDR_W,
  parameter int INSTR_W = cpu_defs::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_defs::NOP_WORD,
  parameter logic [4:0] HALT_OP = cpu_defs::HALT_OP,
  parameter int CNT_W   = cpu_defs::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [ADDR_W-1:0] pc_q;
  logic              halted_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              capture;
  logic              is_halt;

  // A normal capture only happens when nothing higher-priority is active.
  assign capture = !redirect && !halted_q && !stall;
  assign is_halt = (imem_rdata[OPC_HI:OPC_LO] == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else if (redirect) begin
      // Cancels any halt taken on a speculatively fetched HALT.
      pc_q     <= redirect_pc;
      halted_q <= 1'b0;
    end else if (capture) begin
      pc_q     <= pc_q + ADDR_W'(1);
      halted_q <= is_halt;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .flush_pc (redirect_pc),
    .bubble   (halted_q),
    .load     (capture),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .valid    (ifid_valid)
  );

  // imem_addr comes straight from the register: no path from redirect.
  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [256];
  logic        use_ovr;
  logic [15:0] ovr_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = use_ovr ? ovr_word : mem[imem_addr];

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [7:0]  rpc;
    logic        ovr;
    logic [15:0] ovr_word;
    logic [7:0]  e_pc;
    logic [15:0] e_instr;
    logic        chk_ifpc;
    logic [7:0]  e_ifpc;
    logic        e_valid;
    logic        e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [15:0] e_instr,
                           input logic chk_ifpc, input logic [7:0] e_ifpc, input logic e_valid,
                           input logic e_halted, input logic [15:0] e_cnt);
    check({tag, ".pc"},     32'(imem_addr),   32'(e_pc));
    check({tag, ".instr"},  32'(ifid_instr),  32'(e_instr));
    if (chk_ifpc) check({tag, ".ifid_pc"}, 32'(ifid_pc), 32'(e_ifpc));
    check({tag, ".valid"},  32'(ifid_valid),  32'(e_valid));
    check({tag, ".halted"}, 32'(halted),      32'(e_halted));
    check({tag, ".count"},  32'(fetch_count), 32'(e_cnt));
  endtask

  task automatic set_vec(input int i, input logic st, input logic rd, input logic [7:0] rpc,
                         input logic ov, input logic [15:0] ow, input logic [7:0] pc,
                         input logic [15:0] ins, input logic cip, input logic [7:0] ipc,
                         input logic v, input logic h, input logic [15:0] c);
    vecs[i] = '{st, rd, rpc, ov, ow, pc, ins, cip, ipc, v, h, c};
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 | 16'(a);
    mem[0]  = 16'h4c04;
    mem[1]  = 16'h1100;
    mem[2]  = 16'h1204;
    mem[18] = 16'h0800;

    //            st rd rpc ov word      pc   instr     cip ifpc v  h  cnt
    set_vec( 0, 0, 0, 0,   0, 16'h0, 1,   16'h4c04, 1, 0,   1, 0, 1);
    set_vec( 1, 0, 0, 0,   0, 16'h0, 2,   16'h1100, 1, 1,   1, 0, 2);
    set_vec( 2, 0, 0, 0,   0, 16'h0, 3,   16'h1204, 1, 2,   1, 0, 3);
    set_vec( 3, 1, 0, 0,   0, 16'h0, 3,   16'h1204, 1, 2,   1, 0, 3);
    set_vec( 4, 1, 0, 0,   0, 16'h0, 3,   16'h1204, 1, 2,   1, 0, 3);
    set_vec( 5, 0, 0, 0,   0, 16'h0, 4,   16'h1003, 1, 3,   1, 0, 4);
    set_vec( 6, 0, 0, 0,   0, 16'h0, 5,   16'h1004, 1, 4,   1, 0, 5);
    set_vec( 7, 0, 1, 11,  0, 16'h0, 11,  16'h0000, 1, 11,  0, 0, 5);
    set_vec( 8, 0, 0, 0,   0, 16'h0, 12,  16'h100b, 1, 11,  1, 0, 6);
    set_vec( 9, 1, 1, 5,   0, 16'h0, 5,   16'h0000, 1, 5,   0, 0, 6);
    set_vec(10, 0, 0, 0,   0, 16'h0, 6,   16'h1005, 1, 5,   1, 0, 7);
    set_vec(11, 0, 1, 17,  0, 16'h0, 17,  16'h0000, 1, 17,  0, 0, 7);
    set_vec(12, 0, 0, 0,   0, 16'h0, 18,  16'h1011, 1, 17,  1, 0, 8);
    set_vec(13, 0, 0, 0,   0, 16'h0, 19,  16'h0800, 1, 18,  1, 1, 9);
    set_vec(14, 0, 0, 0,   0, 16'h0, 19,  16'h0000, 0, 0,   0, 1, 9);
    set_vec(15, 1, 0, 0,   0, 16'h0, 19,  16'h0000, 0, 0,   0, 1, 9);
    set_vec(16, 0, 1, 1,   0, 16'h0, 1,   16'h0000, 1, 1,   0, 0, 9);
    set_vec(17, 0, 0, 0,   0, 16'h0, 2,   16'h1100, 1, 1,   1, 0, 10);
    set_vec(18, 0, 1, 2,   1, 16'h0800, 2, 16'h0000, 1, 2,   0, 0, 10);
    set_vec(19, 0, 0, 0,   0, 16'h0, 3,   16'h1204, 1, 2,   1, 0, 11);
    set_vec(20, 0, 1, 18,  0, 16'h0, 18,  16'h0000, 1, 18,  0, 0, 11);
    set_vec(21, 1, 0, 0,   0, 16'h0, 18,  16'h0000, 1, 18,  0, 0, 11);
    set_vec(22, 0, 0, 0,   0, 16'h0, 19,  16'h0800, 1, 18,  1, 1, 12);
    set_vec(23, 0, 1, 254, 0, 16'h0, 254, 16'h0000, 1, 254, 0, 0, 12);
    set_vec(24, 0, 0, 0,   0, 16'h0, 255, 16'h10fe, 1, 254, 1, 0, 13);
    set_vec(25, 0, 0, 0,   0, 16'h0, 0,   16'h10ff, 1, 255, 1, 0, 14);
    set_vec(26, 0, 0, 0,   0, 16'h0, 1,   16'h4c04, 1, 0,   1, 0, 15);

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;
    use_ovr = 1'b0; ovr_word = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", 8'd0, 16'h0000, 1'b1, 8'd0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      use_ovr     = vecs[i].ovr;
      ovr_word    = vecs[i].ovr_word;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].chk_ifpc,
                vecs[i].e_ifpc, vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_cnt);
    end
    stall = 1'b0; redirect = 1'b0; use_ovr = 1'b0;

    // Halt, then assert reset together with redirect: reset must win and clear everything.
    redirect = 1'b1; redirect_pc = 8'd18;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(posedge clk); #1;
    check("pre_reset.halted", 32'(halted), 32'd1);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 8'd40;
    @(posedge clk); #1;
    check_all("mid_reset", 8'd0, 16'h0000, 1'b1, 8'd0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0; redirect = 1'b0;

    // Counter saturation: free-run with no HALT word in memory.
    mem[18] = 16'h1012;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.count_fffe", 32'(fetch_count), 32'hfffe);
    @(posedge clk); #1;
    check("sat.count_ffff", 32'(fetch_count), 32'hffff);
    @(posedge clk); #1;
    check("sat.count_stick", 32'(fetch_count), 32'hffff);
    check("sat.valid", 32'(ifid_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 16-bit pipelined CPU; sits directly upstream of instr_mem and directly downstream of the branch/hazard logic.
- Owns the 8-bit PC and drives the instruction-memory address.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, HALT freeze, and a fetched-instruction counter.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 16, instruction word width; opcode is bits [15:11].
- NOP_WORD, 16'h0000, word injected into IF/ID on flush or bubble.
- HALT_OP, 5'b00001, opcode that freezes fetch.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  ADDR_W  address to instr_mem; equals the pc register.
- imem_rdata  in  INSTR_W  instruction word; combinational from imem_addr within the same cycle.
- stall  in  1  from hazard unit; hold PC and IF/ID.
- redirect  in  1  taken branch/jump/jmpr resolved downstream.
- redirect_pc  in  ADDR_W  target address for redirect.
- ifid_instr  out  INSTR_W  IF/ID instruction.
- ifid_pc  out  ADDR_W  address of ifid_instr.
- ifid_valid  out  1  1 = real fetched instruction; 0 = bubble.
- halted  out  1  fetch frozen by HALT.
- fetch_count  out  CNT_W  number of valid instructions captured into IF/ID; saturating.

Behaviour:
- Reset (synchronous, highest priority): pc=0, ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0, halted=0, fetch_count=0. Reset asserted mid-operation discards all state on that edge.
- Priority at each edge after reset: redirect > halted > stall > normal.
- Normal (no redirect, not halted, no stall):
  - ifid_instr=imem_rdata, ifid_pc=pc, ifid_valid=1.
  - pc=pc+1 modulo 2^ADDR_W, so 255 wraps to 0.
  - fetch_count increments, saturating at all-ones.
- HALT capture: a normal capture where imem_rdata[15:11]==HALT_OP sets halted=1 on the same edge.
  - The HALT word itself enters IF/ID (valid=1, counted).
  - pc still advances by 1 on that edge.
- Halted (no redirect): pc frozen; ifid_instr=NOP_WORD, ifid_valid=0; counter frozen. Stall is ignored while halted.
- Stall (not halted, no redirect): pc, ifid_*, and fetch_count all hold.
- Redirect:
  - pc=redirect_pc, ifid_instr=NOP_WORD, ifid_valid=0, ifid_pc=redirect_pc, halted=0.
  - Overrides stall and halted, so a speculatively fetched HALT is cancelled.
  - Fetch of redirect_pc occurs on the following edge.
- Redirect and HALT in the same cycle: redirect wins; halted stays 0 and the HALT word is not captured.
- Latency: an instruction at address A appears on ifid_instr one edge after pc==A with no stall or redirect.
- Branch penalty: 1 bubble in IF/ID per redirect; additional squashing downstream is not this block's concern.
- imem_addr is purely the pc register; no combinational path from redirect to imem_addr.

Decomposition:
- Shared package cpu_defs holds:
  - opcode constants (NOP, HALT, LOAD, STORE, LDIH, ADD…BNC, NOR, NXOR, NAND);
  - register codes gr0–gr7;
  - NOP_WORD and the opcode field bounds [15:11].
- One sub-module is natural: if_id_reg, holding instr/pc/valid with load, hold and flush controls. The PC, halt flag and counter stay in fetch_stage.

Test Plan:
- Sequential fetch: reset, then 3 edges with memory words 16'h4c04, 16'h1100, 16'h1204 at addresses 0–2.
  - ifid_instr steps through 4c04/1100/1204; ifid_pc 0/1/2; pc=3; fetch_count=3.
- Stall: assert stall for 2 cycles while pc=3.
  - pc stays 3; ifid holds 1204 with valid=1; count stays 3.
  - After release, the next edge captures address 3.
- Redirect: at pc=5, pulse redirect with redirect_pc=11.
  - Next edge: ifid_valid=0, ifid_instr=0000, pc=11.
  - Following edge: ifid_pc=11, valid=1.
  - Redirect held together with stall gives the same result.
- HALT: word 16'h0800 at address 18.
  - After capture: halted=1, ifid_instr=0800, pc=19.
  - Subsequent edges: ifid_valid=0, pc frozen at 19, count frozen.
  - Then redirect to 1: halted=0 and fetch resumes at 1.
- Same-cycle redirect and HALT: imem_rdata=16'h0800 with redirect=1, redirect_pc=2 → halted=0, ifid_valid=0, pc=2.
- Wrap and saturation:
  - Run from pc=254 → ifid_pc sequence 254, 255, 0.
  - Preload the counter near max (force) → fetch_count sticks at 16'hFFFF.
  - Reset mid-run clears everything on one edge.
